// File: rtl/soml_pkg.sv
// soml_pkg: shared 16-QAM constants, state enum and axis mapping for the SOML tx/rx pair
package soml_pkg;
  localparam int DW = 16;
  localparam logic signed [DW-1:0] LVL1 = 16'sd1295;
  localparam logic signed [DW-1:0] LVL3 = 16'sd3885;
  typedef enum logic [1:0] {IDLE, SLOT0, SLOT1} state_t;
  // Gray-coded axis: 00 -3, 01 -1, 11 +1, 10 +3
  function automatic logic signed [DW-1:0] qam16_axis(input logic [1:0] b);
    return b == 2'b00 ? -LVL3 : b == 2'b01 ? -LVL1 : b == 2'b11 ? LVL1 : LVL3;
  endfunction
endpackage

// File: rtl/qam16_mapper.sv
// qam16_mapper: combinational 4-bit symbol to Q3.12 I/Q pair
module qam16_mapper
  import soml_pkg::*;
(
  input  logic [3:0]           sym,
  output logic signed [DW-1:0] sym_i,
  output logic signed [DW-1:0] sym_q
);
  assign sym_i = qam16_axis(sym[3:2]);
  assign sym_q = qam16_axis(sym[1:0]);
endmodule

// File: rtl/alamouti_tx_encoder.sv
// alamouti_tx_encoder: maps a 16-QAM symbol pair and emits a two-slot Alamouti block on two antennas
module alamouti_tx_encoder
  import soml_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_slot,
  output logic signed [DW-1:0] tx0_i,
  output logic signed [DW-1:0] tx0_q,
  output logic signed [DW-1:0] tx1_i,
  output logic signed [DW-1:0] tx1_q
);
  state_t state, state_nx;
  logic acc;
  logic signed [DW-1:0] m1i, m1q, m2i, m2q;
  logic signed [DW-1:0] s1i, s1q, s2i, s2q;

  qam16_mapper u_map_s1 (.sym(in_bits[7:4]), .sym_i(m1i), .sym_q(m1q));
  qam16_mapper u_map_s2 (.sym(in_bits[3:0]), .sym_i(m2i), .sym_q(m2q));

  always_comb begin
    in_ready  = state == IDLE || (state == SLOT1 && out_ready);
    acc       = in_valid && in_ready;
    state_nx  = acc ? SLOT0
              : (state == SLOT0 && out_ready) ? SLOT1
              : (state == SLOT1 && out_ready) ? IDLE : state;
    out_valid = state != IDLE;
    out_slot  = state == SLOT1;
    // slot 1 carries (-conj(s2), conj(s1))
    tx0_i = state == SLOT0 ? s1i : state == SLOT1 ? -s2i : '0;
    tx0_q = state == SLOT0 ? s1q : state == SLOT1 ?  s2q : '0;
    tx1_i = state == SLOT0 ? s2i : state == SLOT1 ?  s1i : '0;
    tx1_q = state == SLOT0 ? s2q : state == SLOT1 ? -s1q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s1i   <= '0;
      s1q   <= '0;
      s2i   <= '0;
      s2q   <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        s1i <= m1i;
        s1q <= m1q;
        s2i <= m2i;
        s2q <= m2q;
      end
    end
  end
endmodule

// File: tb/tb_alamouti_tx_encoder.sv
// tb_alamouti_tx_encoder: randomized scoreboard bench for the Alamouti transmit encoder
module tb_alamouti_tx_encoder;
  import soml_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [7:0] in_bits = '0;
  logic in_ready, out_valid, out_slot;
  logic signed [DW-1:0] tx0_i, tx0_q, tx1_i, tx1_q;

  typedef struct {int slot; int a; int b; int c; int d;} exp_t;
  exp_t exq[$];
  int n_chk = 0, n_fail = 0;
  int run = 0, max_run = 0;
  int p_tx1_i = 0, p_tx0_q = 0;
  bit mon_en = 0, rnd_ready = 0;

  alamouti_tx_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_slot(out_slot),
    .tx0_i(tx0_i), .tx0_q(tx0_q), .tx1_i(tx1_i), .tx1_q(tx1_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int lvl(input logic [1:0] b);
    int t[4] = '{-3885, -1295, 3885, 1295};
    return t[b];
  endfunction

  function automatic bit mag_ok(input int v);
    return v == 1295 || v == -1295 || v == 3885 || v == -3885;
  endfunction

  function automatic void push_pair(input logic [7:0] b);
    int a1i = lvl(b[7:6]), a1q = lvl(b[5:4]), a2i = lvl(b[3:2]), a2q = lvl(b[1:0]);
    exq.push_back('{0, a1i, a1q, a2i, a2q});
    exq.push_back('{1, -a2i, a2q, a1i, -a1q});
  endfunction

  always @(negedge clk) if (mon_en) begin
    run = out_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
    check("in_ready", int'(in_ready),
          exq.size() == 0 ? 1 : exq.size() == 1 ? int'(out_ready) : 0);
    check("out_valid", int'(out_valid), int'(exq.size() > 0));
    if (exq.size() == 0) begin
      check("idle_slot", int'(out_slot), 0);
      check("idle_tx", int'(tx0_i | tx0_q | tx1_i | tx1_q), 0);
    end else begin
      check("slot", int'(out_slot), exq[0].slot);
      check("tx0_i", int'(tx0_i), exq[0].a);
      check("tx0_q", int'(tx0_q), exq[0].b);
      check("tx1_i", int'(tx1_i), exq[0].c);
      check("tx1_q", int'(tx1_q), exq[0].d);
      check("mag", int'(mag_ok(tx0_i) && mag_ok(tx0_q) && mag_ok(tx1_i) && mag_ok(tx1_q)), 1);
      if (exq[0].slot == 1) begin
        check("conj_i", int'(tx0_i), -p_tx1_i);
        check("conj_q", int'(tx1_q), -p_tx0_q);
      end else begin
        p_tx1_i = int'(tx1_i);
        p_tx0_q = int'(tx0_q);
      end
    end
    if (rst) exq.delete();
    else begin
      if (out_ready && exq.size() > 0) void'(exq.pop_front());
      if (in_valid && in_ready) push_pair(in_bits);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom % 4) != 0;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1;
    in_bits  = b;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        cyc();
        in_valid = 0;
        return;
      end
    end
    in_valid = 0;
    check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exq.size() > 0; n++) @(negedge clk);
    check("drain", exq.size(), 0);
  endtask

  logic signed [DW-1:0] snap [4];

  initial begin
    repeat (3) cyc();
    rst = 0;
    mon_en = 1;
    @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_ready", int'(in_ready), 1);
    cyc();
    // single block, reference numbers worked by hand
    send(8'hB2);
    @(negedge clk);
    check("b2_s0_t0i", int'(tx0_i), 3885);
    check("b2_s0_t0q", int'(tx0_q), 1295);
    check("b2_s0_t1i", int'(tx1_i), -3885);
    check("b2_s0_t1q", int'(tx1_q), 3885);
    @(negedge clk);
    check("b2_s1_slot", int'(out_slot), 1);
    check("b2_s1_t0i", int'(tx0_i), 3885);
    check("b2_s1_t0q", int'(tx0_q), 3885);
    check("b2_s1_t1i", int'(tx1_i), 3885);
    check("b2_s1_t1q", int'(tx1_q), -1295);
    @(negedge clk);
    check("b2_done", int'(out_valid), 0);
    cyc();
    drain();
    cyc();
    max_run = 0;
    send(8'h1E);
    send(8'h7C);
    send(8'hD5);
    drain();
    check("b2b_run", max_run, 6);
    cyc();
    // backpressure during slot 1
    send(8'h69);
    cyc();
    out_ready = 0;
    @(negedge clk);
    snap = '{tx0_i, tx0_q, tx1_i, tx1_q};
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_slot", int'(out_slot), 1);
      check("bp_hold", int'({tx0_i, tx0_q, tx1_i, tx1_q} == {snap[0], snap[1], snap[2], snap[3]}), 1);
      check("bp_ready", int'(in_ready), 0);
    end
    cyc();
    out_ready = 1;
    @(negedge clk);
    check("bp_last", int'(out_valid && out_slot), 1);
    @(negedge clk);
    check("bp_once", int'(out_valid), 0);
    cyc();
    // reset mid-block during slot 0
    send(8'h3A);
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    check("mr_valid", int'(out_valid), 0);
    check("mr_tx", int'(tx0_i | tx0_q | tx1_i | tx1_q), 0);
    check("mr_ready", int'(in_ready), 1);
    cyc();
    send(8'hC4);
    drain();
    cyc();
    // full mapping sweep with random gaps and random backpressure
    rnd_ready = 1;
    for (int v = 0; v < 256; v++) begin
      repeat ($urandom % 3) cyc();
      send(8'(v));
    end
    for (int k = 0; k < 64; k++) begin
      repeat ($urandom % 2) cyc();
      send(8'($urandom));
    end
    drain();
    rnd_ready = 0;
    cyc();
    out_ready = 1;
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
